adc_scan: RTL

ADC_SCAN -- requirements
Module: adc_scan

---
 rtl/adc_pkg.sv | 16 +
 rtl/adc_scan_if.sv | 11 +
 rtl/adc_spi_frame.sv | 66 ++++++
 rtl/adc_scan.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/adc_pkg.sv
// Shared constants, FSM state type and frame-word helper for the ADC scanner.
// Frame layout: bits 15..14 zero, 13..11 channel address, 10..0 zero.
package adc_pkg;
   localparam int ADC_FRAME_BITS = 16;
   localparam int ADC_RES_W      = 12;
   localparam int ADC_ADDR_MSB   = 13;
   localparam int ADC_ADDR_LSB   = 11;
   localparam int ADC_ADDR_W     = ADC_ADDR_MSB - ADC_ADDR_LSB + 1;

   typedef enum logic [1:0] {IDLE, CS_SETUP, SHIFT, CS_HOLD} scan_state_t;

   function automatic logic [ADC_FRAME_BITS-1:0] frame_word(input logic [ADC_ADDR_W-1:0] addr);
      frame_word = '0;
      frame_word[ADC_ADDR_MSB:ADC_ADDR_LSB] = addr;
   endfunction
endpackage

// File: rtl/adc_scan_if.sv
// Serial converter bus: chip select, clock, address out, data in.
// No flow control; the master owns all timing.
interface adc_scan_if;
   logic adc_cs_n;
   logic adc_sclk;
   logic adc_sdi;
   logic adc_sdo;

   modport master (output adc_cs_n, adc_sclk, adc_sdi, input adc_sdo);
   modport slave  (input adc_cs_n, adc_sclk, adc_sdi, output adc_sdo);
endinterface

// File: rtl/adc_spi_frame.sv
// One 16-bit converter frame: SCLK generation, address shift-out, result capture.
// Takes 32*CLK_DIV cycles from start; done is a one-cycle pulse in the final cycle; no backpressure.
module adc_spi_frame
   import adc_pkg::*;
#(
   parameter int CLK_DIV = 4
) (
   input  logic                      sys_clk,
   input  logic                      reset,
   input  logic                      start,
   input  logic [ADC_FRAME_BITS-1:0] tx_word,
   input  logic                      sdo,
   output logic                      sclk,
   output logic                      sdi,
   output logic                      done,
   output logic [ADC_RES_W-1:0]      sample
);
   logic                      busy;
   logic                      high;
   logic [7:0]                cnt;
   logic [3:0]                bit_cnt;
   logic [ADC_FRAME_BITS-1:0] tx;
   logic                      phase_end;

   assign phase_end = busy && (cnt == 8'(CLK_DIV - 1));
   assign done      = phase_end && high && (bit_cnt == 4'(ADC_FRAME_BITS - 1));

   // The 12-bit shift register keeps only the last 12 bits captured, MSB first.
   always_ff @(posedge sys_clk) begin
      if (reset) begin
         busy    <= 1'b0;
         high    <= 1'b0;
         cnt     <= '0;
         bit_cnt <= '0;
         tx      <= '0;
         sclk    <= 1'b1;
         sdi     <= 1'b0;
         sample  <= '0;
      end else if (start && !busy) begin
         busy    <= 1'b1;
         high    <= 1'b0;
         cnt     <= '0;
         bit_cnt <= '0;
         sclk    <= 1'b0;
         sdi     <= tx_word[ADC_FRAME_BITS-1];
         tx      <= tx_word << 1;
      end else if (busy) begin
         cnt <= phase_end ? '0 : cnt + 8'd1;
         if (phase_end && !high) begin
            sample <= {sample[ADC_RES_W-2:0], sdo};
            high   <= 1'b1;
            sclk   <= 1'b1;
         end else if (phase_end && high) begin
            high <= 1'b0;
            if (done) begin
               busy <= 1'b0;
            end else begin
               bit_cnt <= bit_cnt + 4'd1;
               sclk    <= 1'b0;
               sdi     <= tx[ADC_FRAME_BITS-1];
               tx      <= tx << 1;
            end
         end
      end
   end
endmodule

// File: rtl/adc_scan.sv
// Round-robin converter scanner with optional per-channel averaging (macro ADC_SCAN_AVG_EN).
// Result publishes one cycle after CS_HOLD entry; free-running, outputs have no backpressure.
module adc_scan
   import adc_pkg::*;
#(
   parameter int NUM_CH   = 8,
   parameter int CLK_DIV  = 4,
   parameter int AVG_LOG2 = 2,
   parameter int OUT_W    = 32
) (
   input  logic                    sys_clk,
   input  logic                    reset,
   input  logic                    enable,
   adc_scan_if.master              spi,
   output logic [NUM_CH*OUT_W-1:0] adc_channels,
   output logic [NUM_CH-1:0]       ch_valid,
   output logic                    scan_done
);
   localparam int         AW       = ADC_ADDR_W;
   localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

   if (NUM_CH < 1 || NUM_CH > 8 || CLK_DIV < 2 || CLK_DIV > 255 ||
       AVG_LOG2 < 0 || AVG_LOG2 > 4 || OUT_W < 12 || OUT_W > 32) begin : g_bad_param
      $error("adc_scan: parameter out of legal range");
   end

   scan_state_t              state, state_nx;
   logic [7:0]               cnt, cnt_nx;
   logic                     start, frame_done;
   logic [AW-1:0]            addr, prev_addr, pend_ch;
   logic                     prev_vld, pend;
   logic [ADC_RES_W-1:0]     sample, pend_smp;
   logic [ADC_FRAME_BITS-1:0] tx_word;
   logic [OUT_W-1:0]         ch_word [NUM_CH];

   assign spi.adc_cs_n = !(state == CS_SETUP || state == SHIFT);
   assign tx_word      = frame_word(addr);

   adc_spi_frame #(.CLK_DIV(CLK_DIV)) u_frame (
      .sys_clk (sys_clk),
      .reset   (reset),
      .start   (start),
      .tx_word (tx_word),
      .sdo     (spi.adc_sdo),
      .sclk    (spi.adc_sclk),
      .sdi     (spi.adc_sdi),
      .done    (frame_done),
      .sample  (sample)
   );

   always_ff @(posedge sys_clk) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
      end
   end

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      start    = 1'b0;
      case (state)
         IDLE: begin
            cnt_nx = '0;
            if (enable) state_nx = CS_SETUP;
         end
         CS_SETUP: begin
            if (cnt == DIV_LAST) begin
               cnt_nx   = '0;
               start    = 1'b1;
               state_nx = SHIFT;
            end else begin
               cnt_nx = cnt + 8'd1;
            end
         end
         SHIFT: begin
            if (frame_done) state_nx = CS_HOLD;
         end
         CS_HOLD: begin
            if (cnt == DIV_LAST) begin
               cnt_nx   = '0;
               state_nx = enable ? CS_SETUP : IDLE;
            end else begin
               cnt_nx = cnt + 8'd1;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // A frame's data belongs to the previous frame's address; prev_vld drops in IDLE so the
   // first frame of every burst is discarded.
   always_ff @(posedge sys_clk) begin
      if (reset) begin
         addr      <= '0;
         prev_addr <= '0;
         prev_vld  <= 1'b0;
         pend      <= 1'b0;
         pend_ch   <= '0;
         pend_smp  <= '0;
      end else begin
         pend <= 1'b0;
         if (frame_done) begin
            pend      <= prev_vld;
            pend_ch   <= prev_addr;
            pend_smp  <= sample;
            prev_addr <= addr;
            prev_vld  <= 1'b1;
            addr      <= (addr == AW'(NUM_CH - 1)) ? '0 : addr + AW'(1);
         end else if (state == IDLE) begin
            prev_vld <= 1'b0;
         end
      end
   end

`ifdef ADC_SCAN_AVG_EN
   localparam int ACC_W = ADC_RES_W + AVG_LOG2;

   logic [ACC_W-1:0] acc     [NUM_CH];
   logic [4:0]       smp_cnt [NUM_CH];
   logic [ACC_W-1:0] acc_sum;
   logic             last_smp;

   assign acc_sum  = acc[pend_ch] + ACC_W'(pend_smp);
   assign last_smp = (smp_cnt[pend_ch] == 5'((1 << AVG_LOG2) - 1));

   always_ff @(posedge sys_clk) begin
      if (reset) begin
         for (int k = 0; k < NUM_CH; k++) begin
            acc[k]     <= '0;
            smp_cnt[k] <= '0;
            ch_word[k] <= '0;
         end
         ch_valid  <= '0;
         scan_done <= 1'b0;
      end else begin
         ch_valid  <= '0;
         scan_done <= 1'b0;
         if (pend) begin
            if (last_smp) begin
               ch_word[pend_ch]  <= OUT_W'(acc_sum >> AVG_LOG2);
               acc[pend_ch]      <= '0;
               smp_cnt[pend_ch]  <= '0;
               ch_valid[pend_ch] <= 1'b1;
               scan_done         <= (pend_ch == AW'(NUM_CH - 1));
            end else begin
               acc[pend_ch]     <= acc_sum;
               smp_cnt[pend_ch] <= smp_cnt[pend_ch] + 5'd1;
            end
         end
      end
   end
`else
   always_ff @(posedge sys_clk) begin
      if (reset) begin
         for (int k = 0; k < NUM_CH; k++) ch_word[k] <= '0;
         ch_valid  <= '0;
         scan_done <= 1'b0;
      end else begin
         ch_valid  <= '0;
         scan_done <= 1'b0;
         if (pend) begin
            ch_word[pend_ch]  <= OUT_W'(pend_smp);
            ch_valid[pend_ch] <= 1'b1;
            scan_done         <= (pend_ch == AW'(NUM_CH - 1));
         end
      end
   end
`endif

   for (genvar k = 0; k < NUM_CH; k++) begin : g_pack
      assign adc_channels[k*OUT_W +: OUT_W] = ch_word[k];
   end
endmodule
